// File: rtl/bsg_fma_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bsg_fma_div_pkg
// Purpose  : Shared types and helpers for the FMA sequential divider.
//            Holds the divider FSM state enum and the step-counter width helper.
// Revision : 1.0 - initial release
// ============================================================================
package bsg_fma_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // The counter must be able to hold width_p itself, hence the +1.
  function automatic int div_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_fma_div_step.sv
`default_nettype none
// ============================================================================
// Module   : bsg_fma_div_step
// Purpose  : One combinational radix-2 restoring division step.
//            The partial remainder is shifted left, the next dividend bit is
//            brought in, and the divisor is trial-subtracted.
// Ports    : rem_i      partial remainder (width_p+1)
//            bit_i      next dividend bit, MSB first
//            divisor_i  divisor (width_p)
//            rem_o      updated partial remainder (width_p+1)
//            q_o        quotient bit produced by this step
// Revision : 1.0 - initial release
// ============================================================================
module bsg_fma_div_step
  import bsg_fma_div_pkg::*;
#(
  parameter int width_p = 8
) (
  input  logic [width_p:0]   rem_i,
  input  logic               bit_i,
  input  logic [width_p-1:0] divisor_i,
  output logic [width_p:0]   rem_o,
  output logic               q_o
);

  logic [width_p+1:0] shifted;
  logic [width_p+1:0] diff;

  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {2'b00, divisor_i};

  // A set top bit means the trial subtract borrowed: restore the shifted value.
  assign q_o   = ~diff[width_p+1];
  assign rem_o = q_o ? diff[width_p:0] : shifted[width_p:0];

endmodule
`default_nettype wire

// File: rtl/bsg_fma_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : bsg_fma_seq_divider
// Purpose  : Iterative radix-2 restoring divider, one quotient bit per cycle,
//            MSB first. valid/ready on the input side, valid/yumi on the
//            result side. A zero divisor returns quotient all ones, remainder
//            equal to the dividend, and div_by_zero_o set.
// Macro    : BSG_FMA_SEQ_DIVIDER_SIGNED_EN - when defined, operands are two's
//            complement (quotient truncates toward zero, remainder takes the
//            dividend's sign). Undefined: fully unsigned.
// Ports    : clk_i, reset_n_i (synchronous, active-low)
//            v_i, ready_o, dividend_i, divisor_i        - request side
//            v_o, yumi_i, quotient_o, remainder_o,
//            div_by_zero_o                              - result side
// Revision : 1.0 - initial release
// ============================================================================
module bsg_fma_seq_divider
  import bsg_fma_div_pkg::*;
#(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] dividend_i,
  input  logic [width_p-1:0] divisor_i,
  output logic               v_o,
  input  logic               yumi_i,
  output logic [width_p-1:0] quotient_o,
  output logic [width_p-1:0] remainder_o,
  output logic               div_by_zero_o
);

  localparam int cnt_w_lp = div_cnt_width(width_p);

  state_e                state_q;
  logic [cnt_w_lp-1:0]   cnt_q;
  // Dividend shifts out MSB first while quotient bits shift in at the LSB;
  // after width_p steps this register holds the quotient.
  logic [width_p-1:0]    dvd_q;
  logic [width_p-1:0]    dsr_q;
  logic [width_p:0]      rem_q;
  logic                  dbz_q;

  logic [width_p:0]      rem_d;
  logic                  qbit_d;
  logic [width_p-1:0]    dvd_mag;
  logic [width_p-1:0]    dsr_mag;

  bsg_fma_div_step #(.width_p(width_p)) step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[width_p-1]),
    .divisor_i (dsr_q),
    .rem_o     (rem_d),
    .q_o       (qbit_d)
  );

`ifdef BSG_FMA_SEQ_DIVIDER_SIGNED_EN
  logic qneg_q;
  logic rneg_q;

  assign dvd_mag = dividend_i[width_p-1] ? (~dividend_i + 1'b1) : dividend_i;
  assign dsr_mag = divisor_i[width_p-1]  ? (~divisor_i + 1'b1)  : divisor_i;

  // Sign flags are cleared on the zero-divisor path, so no fix-up applies there.
  assign quotient_o  = qneg_q ? (~dvd_q + 1'b1) : dvd_q;
  assign remainder_o = rneg_q ? (~rem_q[width_p-1:0] + 1'b1) : rem_q[width_p-1:0];
`else
  assign dvd_mag     = dividend_i;
  assign dsr_mag     = divisor_i;
  assign quotient_o  = dvd_q;
  assign remainder_o = rem_q[width_p-1:0];
`endif

  assign ready_o       = (state_q == IDLE);
  assign v_o           = (state_q == DONE);
  assign div_by_zero_o = dbz_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef BSG_FMA_SEQ_DIVIDER_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (v_i) begin
            if (divisor_i == '0) begin
              dvd_q   <= '1;
              rem_q   <= {1'b0, dividend_i};
              dsr_q   <= '0;
              dbz_q   <= 1'b1;
              state_q <= DONE;
`ifdef BSG_FMA_SEQ_DIVIDER_SIGNED_EN
              qneg_q  <= 1'b0;
              rneg_q  <= 1'b0;
`endif
            end else begin
              dvd_q   <= dvd_mag;
              dsr_q   <= dsr_mag;
              rem_q   <= '0;
              dbz_q   <= 1'b0;
              cnt_q   <= cnt_w_lp'(width_p);
              state_q <= CALC;
`ifdef BSG_FMA_SEQ_DIVIDER_SIGNED_EN
              qneg_q  <= dividend_i[width_p-1] ^ divisor_i[width_p-1];
              rneg_q  <= dividend_i[width_p-1];
`endif
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          dvd_q <= {dvd_q[width_p-2:0], qbit_d};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == cnt_w_lp'(1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (yumi_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bsg_fma_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_fma_seq_divider
// Purpose  : Directed self-checking bench for bsg_fma_seq_divider (width 8).
//            Signed vectors are selected by BSG_FMA_SEQ_DIVIDER_SIGNED_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_fma_seq_divider;

  localparam int W = 8;

  logic         clk_i      = 1'b0;
  logic         reset_n_i  = 1'b0;
  logic         v_i        = 1'b0;
  logic         yumi_i     = 1'b0;
  logic [W-1:0] dividend_i = '0;
  logic [W-1:0] divisor_i  = '0;
  logic         ready_o;
  logic         v_o;
  logic [W-1:0] quotient_o;
  logic [W-1:0] remainder_o;
  logic         div_by_zero_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  bsg_fma_seq_divider #(.width_p(W)) dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .v_i           (v_i),
    .ready_o       (ready_o),
    .dividend_i    (dividend_i),
    .divisor_i     (divisor_i),
    .v_o           (v_o),
    .yumi_i        (yumi_i),
    .quotient_o    (quotient_o),
    .remainder_o   (remainder_o),
    .div_by_zero_o (div_by_zero_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full transaction: accept in cycle 0, count cycles to v_o, check the
  // result, optionally stall the consumer, then yumi and check the return to IDLE.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                       input int elat, input int hold, input bit poke);
    int cyc;
    cyc = 0;
    while (!ready_o && cyc < 20) begin tick(); cyc++; end
    check({tag, " ready_in"}, 32'(ready_o), 32'd1);
    dividend_i = a; divisor_i = b; v_i = 1'b1;
    tick();
    v_i = 1'b0;
    cyc = 1;
    while (!v_o && cyc < 40) begin
      if (poke && cyc == 3) begin
        v_i = 1'b1; dividend_i = 8'd5; divisor_i = 8'd1;
      end
      tick();
      v_i = 1'b0;
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(elat));
    check({tag, " quotient"}, 32'(quotient_o), 32'(eq));
    check({tag, " remainder"}, 32'(remainder_o), 32'(er));
    check({tag, " dbz"}, 32'(div_by_zero_o), 32'(edbz));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " hold_v"}, 32'(v_o), 32'd1);
      check({tag, " hold_ready"}, 32'(ready_o), 32'd0);
      check({tag, " hold_q"}, 32'(quotient_o), 32'(eq));
      check({tag, " hold_r"}, 32'(remainder_o), 32'(er));
    end
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    check({tag, " ready_after_yumi"}, 32'(ready_o), 32'd1);
    check({tag, " v_after_yumi"}, 32'(v_o), 32'd0);
  endtask

  initial begin
    // Reset state, both during reset and in the first cycle after release.
    tick();
    check("rst ready", 32'(ready_o), 32'd1);
    check("rst v", 32'(v_o), 32'd0);
    check("rst q", 32'(quotient_o), 32'd0);
    check("rst r", 32'(remainder_o), 32'd0);
    check("rst dbz", 32'(div_by_zero_o), 32'd0);
    reset_n_i = 1'b1;
    tick();
    check("post_rst ready", 32'(ready_o), 32'd1);
    check("post_rst v", 32'(v_o), 32'd0);
    check("post_rst q", 32'(quotient_o), 32'd0);

    // Illegal yumi outside DONE must be ignored.
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    check("stray_yumi ready", 32'(ready_o), 32'd1);
    check("stray_yumi v", 32'(v_o), 32'd0);

    // Basic divide with a 5-cycle consumer stall.
    do_op("200/7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9, 5, 1'b0);
    do_op("55/0", 8'd55, 8'd0, 8'hFF, 8'd55, 1'b1, 1, 2, 1'b0);
    do_op("255/1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9, 0, 1'b0);
    do_op("0/5", 8'd0, 8'd5, 8'd0, 8'd0, 1'b0, 9, 0, 1'b0);
    do_op("5/255", 8'd5, 8'd255, 8'd0, 8'd5, 1'b0, 9, 0, 1'b0);
    do_op("255/255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 9, 0, 1'b0);
    do_op("128/3", 8'd128, 8'd3, 8'd42, 8'd2, 1'b0, 9, 0, 1'b0);
    do_op("254/16", 8'd254, 8'd16, 8'd15, 8'd14, 1'b0, 9, 0, 1'b0);
    do_op("0/0", 8'd0, 8'd0, 8'hFF, 8'd0, 1'b1, 1, 0, 1'b0);
    // v_i during CALC must not disturb the in-flight 100/9.
    do_op("100/9 poke", 8'd100, 8'd9, 8'd11, 8'd1, 1'b0, 9, 0, 1'b1);

    // Mid-operation reset: pulse reset in cycle 4 of CALC.
    dividend_i = 8'd200; divisor_i = 8'd7; v_i = 1'b1;
    tick();
    v_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    reset_n_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    check("midrst ready", 32'(ready_o), 32'd1);
    check("midrst v", 32'(v_o), 32'd0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (v_o) seen++;
      end
      check("midrst v_never", 32'(seen), 32'd0);
    end
    do_op("9/3 after rst", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 9, 0, 1'b0);

`ifdef BSG_FMA_SEQ_DIVIDER_SIGNED_EN
    do_op("-7/2", 8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, 9, 0, 1'b0);
    do_op("7/-2", 8'd7, 8'hFE, 8'hFD, 8'd1, 1'b0, 9, 0, 1'b0);
    do_op("-7/-2", 8'hF9, 8'hFE, 8'd3, 8'hFF, 1'b0, 9, 0, 1'b0);
    do_op("-128/-1", 8'h80, 8'hFF, 8'h80, 8'd0, 1'b0, 9, 0, 1'b0);
    do_op("-7/0", 8'hF9, 8'd0, 8'hFF, 8'hF9, 1'b1, 1, 0, 1'b0);
`else
    do_op("249/2", 8'hF9, 8'd2, 8'd124, 8'd1, 1'b0, 9, 0, 1'b0);
    do_op("7/254", 8'd7, 8'hFE, 8'd0, 8'd7, 1'b0, 9, 0, 1'b0);
    do_op("249/254", 8'hF9, 8'hFE, 8'd0, 8'hF9, 1'b0, 9, 0, 1'b0);
    do_op("128/255", 8'h80, 8'hFF, 8'd0, 8'h80, 1'b0, 9, 0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
